// File: rtl/fp_addsub.sv
// Multi-cycle IEEE-style floating-point adder/subtractor with parameterised format.
// One FSM state per datapath step; result and flags are held until the next result.
module fp_addsub #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic                   op,
    input  logic [1:0]             rm,
    output logic                   busy,
    output logic [EXP_W+MAN_W:0]   out_z,
    output logic                   out_valid,
    input  logic                   out_ack,
    output logic                   flag_invalid,
    output logic                   flag_overflow,
    output logic                   flag_underflow,
    output logic                   flag_inexact
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int M  = MAN_W + 1;          // mantissa incl. hidden bit
    localparam int XW = M + 3;              // mantissa + guard/round/sticky
    localparam int SW = M + 4;              // plus carry-out
    localparam int CW = (EXP_W + 2 > 8) ? EXP_W + 2 : 8;
    localparam logic [CW-1:0] EMAX = CW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]  QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [3:0] {
        IDLE, UNPACK, SPECIAL, ALIGN, ADD, NORM, ROUND, PACK, DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, out_z_q, out_z_d;
    logic            op_q, op_d;
    logic [1:0]      rm_q, rm_d;
    logic            sx_q, sx_d, sy_q, sy_d, eff_sub_q, eff_sub_d;
    logic [CW-1:0]   ex_q, ex_d, ey_q, ey_d;
    logic [M-1:0]    mx_q, mx_d, my_q, my_d, rman_q, rman_d;
    logic [XW-1:0]   al_q, al_d;
    logic [SW-1:0]   sum_q, sum_d;
    logic            rinx_q, rinx_d;
    logic [3:0]      flags_q, flags_d;      // {invalid, overflow, underflow, inexact}
    logic            out_valid_q, out_valid_d;

    logic [EXP_W-1:0] ea_f, eb_f;
    logic [MAN_W-1:0] fa, fb;
    logic             nan_a, nan_b, inf_a, inf_b;
    logic [CW-1:0]    diff, ash, lzc, lim, nsh;
    logic [XW-1:0]    ext, mask;
    logic [M-1:0]     man;
    logic             g, rs, inc, s, ovf, to_inf;
    logic [M:0]       rsum;

    assign ea_f = a_q[W-2:MAN_W];
    assign eb_f = b_q[W-2:MAN_W];
    assign fa   = a_q[MAN_W-1:0];
    assign fb   = b_q[MAN_W-1:0];

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        rm_d        = rm_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        eff_sub_d   = eff_sub_q;
        ex_d        = ex_q;
        ey_d        = ey_q;
        mx_d        = mx_q;
        my_d        = my_q;
        al_d        = al_q;
        sum_d       = sum_q;
        rman_d      = rman_q;
        rinx_d      = rinx_q;
        out_z_d     = out_z_q;
        flags_d     = flags_q;
        out_valid_d = 1'b0;

        nan_a = (&ea_f) && (|fa);
        nan_b = (&eb_f) && (|fb);
        inf_a = (&ea_f) && !(|fa);
        inf_b = (&eb_f) && !(|fb);

        diff = ex_q - ey_q;
        ash  = (diff > CW'(XW-1)) ? CW'(XW-1) : diff;
        ext  = {my_q, 3'b000};
        mask = ~({XW{1'b1}} << ash);

        // Leading zeros above the guard bits; an all-zero sum counts every bit.
        lzc = CW'(SW-1);
        for (int i = 0; i < SW-1; i++)
            if (sum_q[i]) lzc = CW'(SW-2-i);
        lim = ex_q - CW'(1);
        nsh = (lzc < lim) ? lzc : lim;

        man = sum_q[SW-2:3];
        g   = sum_q[2];
        rs  = |sum_q[1:0];
        case (rm_q)
            2'd0:    inc = g & (rs | man[0]);
            2'd2:    inc = !sx_q & (g | rs);
            2'd3:    inc = sx_q & (g | rs);
            default: inc = 1'b0;
        endcase
        rsum = {1'b0, man} + (M+1)'(inc);

        // Exact cancellation yields +0, or -0 when rounding toward -inf.
        s      = (rman_q == '0 && !rinx_q && eff_sub_q) ? (rm_q == 2'd3) : sx_q;
        ovf    = ex_q >= EMAX;
        to_inf = (rm_q == 2'd0) || (rm_q == 2'd2 && !s) || (rm_q == 2'd3 && s);

        case (state_q)
            IDLE: if (start) begin
                a_d     = in_a;
                b_d     = in_b;
                op_d    = op;
                rm_d    = rm;
                state_d = UNPACK;
            end
            UNPACK: begin
                sx_d    = a_q[W-1];
                sy_d    = b_q[W-1] ^ op_q;
                ex_d    = (ea_f == '0) ? CW'(1) : CW'(ea_f);
                ey_d    = (eb_f == '0) ? CW'(1) : CW'(eb_f);
                mx_d    = {ea_f != '0, fa};
                my_d    = {eb_f != '0, fb};
                state_d = SPECIAL;
            end
            SPECIAL: begin
                state_d = DONE;
                flags_d = 4'b0000;
                if (nan_a || nan_b || (inf_a && inf_b && sx_q != sy_q)) begin
                    out_z_d = QNAN;
                    flags_d = 4'b1000;
                end else if (inf_a) begin
                    out_z_d = {sx_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                end else if (inf_b) begin
                    out_z_d = {sy_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                end else begin
                    flags_d   = flags_q;
                    eff_sub_d = sx_q ^ sy_q;
                    state_d   = ALIGN;
                    // Larger magnitude goes to x so subtraction never goes negative.
                    if ({ey_q, my_q} > {ex_q, mx_q}) begin
                        sx_d = sy_q; sy_d = sx_q;
                        ex_d = ey_q; ey_d = ex_q;
                        mx_d = my_q; my_d = mx_q;
                    end
                end
            end
            ALIGN: begin
                al_d    = (ext >> ash) | XW'(|(ext & mask));
                state_d = ADD;
            end
            ADD: begin
                sum_d   = eff_sub_q ? ({1'b0, mx_q, 3'b000} - {1'b0, al_q})
                                    : ({1'b0, mx_q, 3'b000} + {1'b0, al_q});
                state_d = NORM;
            end
            NORM: begin
                if (sum_q[SW-1]) begin
                    sum_d = {1'b0, sum_q[SW-1:2], sum_q[1] | sum_q[0]};
                    ex_d  = ex_q + CW'(1);
                end else begin
                    sum_d = sum_q << nsh;
                    ex_d  = ex_q - nsh;
                end
                state_d = ROUND;
            end
            ROUND: begin
                rman_d  = rsum[M] ? {1'b1, rsum[M-1:1]} : rsum[M-1:0];
                ex_d    = ex_q + CW'(rsum[M]);
                rinx_d  = g | rs;
                state_d = PACK;
            end
            PACK: begin
                if (ovf) begin
                    out_z_d = to_inf ? {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                                     : {s, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
                    flags_d = 4'b0101;
                end else begin
                    out_z_d = {s, rman_q[M-1] ? ex_q[EXP_W-1:0] : {EXP_W{1'b0}},
                               rman_q[MAN_W-1:0]};
                    flags_d = {2'b00, !rman_q[M-1] & rinx_q, rinx_q};
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_valid_q && out_ack) state_d = IDLE;
                else                        out_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 1'b0;
            rm_q        <= 2'd0;
            sx_q        <= 1'b0;
            sy_q        <= 1'b0;
            eff_sub_q   <= 1'b0;
            ex_q        <= '0;
            ey_q        <= '0;
            mx_q        <= '0;
            my_q        <= '0;
            al_q        <= '0;
            sum_q       <= '0;
            rman_q      <= '0;
            rinx_q      <= 1'b0;
            out_z_q     <= '0;
            flags_q     <= 4'b0000;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            rm_q        <= rm_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            eff_sub_q   <= eff_sub_d;
            ex_q        <= ex_d;
            ey_q        <= ey_d;
            mx_q        <= mx_d;
            my_q        <= my_d;
            al_q        <= al_d;
            sum_q       <= sum_d;
            rman_q      <= rman_d;
            rinx_q      <= rinx_d;
            out_z_q     <= out_z_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign busy           = (state_q != IDLE);
    assign out_z          = out_z_q;
    assign out_valid      = out_valid_q;
    assign flag_invalid   = flags_q[3];
    assign flag_overflow  = flags_q[2];
    assign flag_underflow = flags_q[1];
    assign flag_inexact   = flags_q[0];
endmodule

// File: doc/fp_addsub.md
FP_ADDSUB -- requirements
Module: fp_addsub

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (range 4..11).
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width (range 4..52); W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1; reset rst, synchronous, active-high; clock clk.
REQ-005 SHALL have port start, input, 1, request; sampled only in IDLE.
REQ-006 SHALL have ports in_a and in_b, input, W each, IEEE-style operands.
REQ-007 SHALL have port op, input, 1; 0 = a+b, 1 = a-b.
REQ-008 SHALL have port rm, input, 2, rounding mode: 0 RNE, 1 RTZ, 2 RUP (toward +inf), 3 RDN (toward -inf).
REQ-009 SHALL have port busy, output, 1; high in every state except IDLE.
REQ-010 SHALL have port out_z, output, W, registered result.
REQ-011 SHALL have port out_valid, output, 1, result-valid.
REQ-012 SHALL have port out_ack, input, 1, consumer acknowledge.
REQ-013 SHALL have ports flag_invalid, flag_overflow, flag_underflow, flag_inexact, output, 1 each, registered with out_z.

Function
REQ-014 SHALL implement FSM IDLE, UNPACK, SPECIAL, ALIGN, ADD, NORM, ROUND, PACK, DONE; one cycle per state except IDLE/DONE.
REQ-015 SHALL, in IDLE with start=1, capture in_a, in_b, op, rm at that edge and enter UNPACK; start in any other state ignored.
REQ-016 SHALL apply op by inverting b's sign in UNPACK.
REQ-017 SHALL, in SPECIAL: NaN operand or inf-inf of opposite effective sign -> canonical qNaN (sign 0, exp all ones, fraction MSB 1, rest 0) + flag_invalid; single inf -> that inf; then go to DONE directly.
REQ-018 SHALL treat exponent 0 as subnormal (effective exponent 1-BIAS, no hidden bit); no flush-to-zero.
REQ-019 SHALL, in ALIGN, shift smaller-exponent mantissa right by exponent difference in one cycle, saturating at MAN_W+3, ORing shifted-out bits into sticky.
REQ-020 SHALL keep MAN_W+1 mantissa bits plus guard, round, sticky through ADD, NORM, ROUND.
REQ-021 SHALL, in NORM, normalise in one cycle: carry-out -> right shift 1 (sticky preserved); else left shift by leading-zero count limited so exponent not below 1-BIAS.
REQ-022 SHALL round per rm: RNE ties-to-even; RTZ truncate; RUP increment if positive and any GRS; RDN increment if negative and any GRS; mantissa overflow from rounding increments exponent.
REQ-023 SHALL set flag_inexact when any GRS bit nonzero before rounding.
REQ-024 SHALL set flag_underflow when result subnormal and inexact.
REQ-025 SHALL on overflow set flag_overflow and flag_inexact; result inf for RNE, max finite for RTZ, +inf/−max for RUP by sign, −inf/+max for RDN by sign.
REQ-026 SHALL give exact zero sum of opposite-signed operands as +0, except -0 under RDN; (-0)+(-0) = -0 in all modes.
REQ-027 SHALL register out_z and flags in PACK (or SPECIAL for special path) and hold them stable until next result.
REQ-028 SHALL assert out_valid in DONE; normal path: first cycle high is 8 edges after start-sampling edge; special path: 3 edges.
REQ-029 SHALL hold out_valid until a cycle with out_valid=1 and out_ack=1; then out_valid=0 and IDLE next cycle; out_ack outside DONE ignored.
REQ-030 SHALL not accept a new start in the same cycle as the ack; earliest new start is the following cycle.

Reset
REQ-031 SHALL, with rst=1 at an edge, in any state (including mid-operation), enter IDLE, clear out_z, all flags, out_valid, busy to 0; rst overrides start and out_ack.
REQ-032 SHALL discard any in-flight operation on reset with no residual output.

Verification (default EXP_W=8, MAN_W=23)
REQ-033 SHALL cover 0x3F800000 + 0x40000000, op=0, rm=RNE -> 0x40400000, flags 0, out_valid 8 edges after start.
REQ-034 SHALL cover 0x3F800000 - 0x3F800000 (op=1): RNE -> 0x00000000; RDN -> 0x80000000; flags 0.
REQ-035 SHALL cover 0x3F800000 + 0x33800000: RNE -> 0x3F800000, RUP -> 0x3F800001, both flag_inexact=1.
REQ-036 SHALL cover 0x7F7FFFFF + 0x7F7FFFFF: RNE -> 0x7F800000, RTZ -> 0x7F7FFFFF, flag_overflow=1 and flag_inexact=1.
REQ-037 SHALL cover 0x7F800000 - 0x7F800000 -> 0x7FC00000, flag_invalid=1, out_valid 3 edges after start; and 0x00000001 + 0x00000001 -> 0x00000002, flags 0.
REQ-038 SHALL cover out_ack held low 5 cycles in DONE (out_z stable, start ignored), and rst pulsed during ALIGN (next cycle busy=0, out_valid=0, out_z=0).
